// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Register $0 is hard-wired to zero; writes to it are swallowed.
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB0  = 2'd1,
        GNT_WB1  = 2'd2
    } gnt_e;

endpackage : rf_wb_arbiter_pkg

// File: rtl/mux_5bit.sv
// Register-address 2:1 multiplexer: ctrl selects b, otherwise a.
module mux_5bit (
    input  logic       ctrl,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] y
);

    assign y = ctrl ? b : a;

endmodule : mux_5bit

// File: rtl/rf_wb_arbiter_mux.sv
// Width-parameterised 2:1 data multiplexer: sel_i selects b_i, otherwise a_i.
module rf_wb_arbiter_mux #(
    parameter int W = 32
) (
    input  logic         sel_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule : rf_wb_arbiter_mux

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline WB
// stage (port 0, fixed priority) and the MDU (port 1, starvation-protected),
// and registers the winning write onto the register file.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    gnt_e              gnt;
    logic              sel_wb1;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] data_sel;

    logic              rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [3:0]        starve_q,   starve_d;

    // Grant decision: forced port 1, else port 0 priority, else port 1; nothing during reset.
    always_comb begin
        // NOTE: assign a default before any branch so every path drives the signal and no latch is inferred.
        gnt = GNT_NONE;
        if (!rst) begin
            if (wb1_valid && (starve_q == STARVE_MAX_C)) gnt = GNT_WB1;
            else if (wb0_valid)                          gnt = GNT_WB0;
            else if (wb1_valid)                          gnt = GNT_WB1;
        end
    end

    assign wb0_ready = (gnt == GNT_WB0);
    assign wb1_ready = (gnt == GNT_WB1);
    assign sel_wb1   = (gnt == GNT_WB1);

    mux_5bit u_addr_mux (
        .ctrl (sel_wb1),
        .a    (wb0_addr),
        .b    (wb1_addr),
        .y    (addr_sel)
    );

    rf_wb_arbiter_mux #(.W(DATA_W)) u_data_mux (
        .sel_i (sel_wb1),
        .a_i   (wb0_data),
        .b_i   (wb1_data),
        .y_o   (data_sel)
    );

    // Next-state for the write port and the starvation counter.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        starve_d   = starve_q;

        if (gnt != GNT_NONE) begin
            rf_we_d    = (addr_sel != ADDR_W'(REG_ZERO));
            rf_waddr_d = addr_sel;
            rf_wdata_d = data_sel;
        end

        // A refused port 1 request ages; a served or withdrawn one starts over.
        if (!wb1_valid || gnt == GNT_WB1) begin
            starve_d = 4'd0;
        end else if (gnt == GNT_WB0 && starve_q < STARVE_MAX_C) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            starve_q   <= 4'd0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            starve_q   <= starve_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign starve_cnt = starve_q;

endmodule : rf_wb_arbiter
